// File: rtl/hex_scroll_ctrl_if.sv
// ---------------------------------------------------------------------------
// hex_scroll_ctrl_if
// Message-buffer write bus for hex_scroll_ctrl.
//   wr_en    1       write strobe, one slot written per cycle it is high
//   wr_addr  PW      message slot to write
//   wr_data  CODE_W  character code to store
// master drives the bus (host / testbench), slave is the scroll controller.
// ---------------------------------------------------------------------------
interface hex_scroll_ctrl_if #(
  parameter int PW     = 3,
  parameter int CODE_W = 3
);
  logic              wr_en;
  logic [PW-1:0]     wr_addr;
  logic [CODE_W-1:0] wr_data;

  modport master (output wr_en, output wr_addr, output wr_data);
  modport slave  (input  wr_en, input  wr_addr, input  wr_data);
endinterface

// File: rtl/hex_scroll_ctrl.sv
// ---------------------------------------------------------------------------
// hex_scroll_ctrl
// Scroll scheduler for a 4-digit HEX message display. Holds a circular
// buffer of MSG_LEN character codes, prescales CLOCK_50 into a scroll tick
// and runs a STOP/RUN/STEP FSM that moves a window pointer over the buffer.
//
// Ports
//   CLOCK_50        in   system clock (rising edge)
//   Resetn          in   asynchronous active-low reset
//   run             in   level, 1 = auto-scroll
//   dir             in   0 = ptr+1 per advance, 1 = ptr-1 per advance
//   step            in   rising edge advances one slot while stopped
//   speed[1:0]      in   scroll period = TICK_DIV >> speed
//   wr              bus  message write port (hex_scroll_ctrl_if.slave)
//   code3..code0    out  window codes, codeK = msg[(ptr + 3 - K) mod MSG_LEN]
//   ptr             out  window start slot
//   tick            out  registered one-cycle pulse per auto-scroll advance
//   state[1:0]      out  0 STOP, 1 RUN, 2 STEP
//
// All outputs come from flops (code* is a mux of flopped buffer and pointer),
// so there is no combinational input-to-output path.
// ---------------------------------------------------------------------------
module hex_scroll_ctrl #(
  parameter int TICK_DIV = 50_000_000,
  parameter int MSG_LEN  = 8,
  parameter int CODE_W   = 3,
  localparam int PW      = $clog2(MSG_LEN)
) (
  input  logic              CLOCK_50,
  input  logic              Resetn,
  input  logic              run,
  input  logic              dir,
  input  logic              step,
  input  logic [1:0]        speed,
  hex_scroll_ctrl_if.slave  wr,
  output logic [CODE_W-1:0] code3,
  output logic [CODE_W-1:0] code2,
  output logic [CODE_W-1:0] code1,
  output logic [CODE_W-1:0] code0,
  output logic [PW-1:0]     ptr,
  output logic              tick,
  output logic [1:0]        state
);

  // Prescaler width: enough to hold TICK_DIV-1, the longest period.
  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [1:0] {
    S_STOP = 2'd0,
    S_RUN  = 2'd1,
    S_STEP = 2'd2
  } state_e;

  typedef logic [MSG_LEN-1:0][CODE_W-1:0] msg_t;

  // Power-on message "HELLO" followed by blanks.
  function automatic msg_t init_msg();
    msg_t m;
    for (int i = 0; i < MSG_LEN; i++) begin
      case (i)
        0:       m[i] = CODE_W'(0);
        1:       m[i] = CODE_W'(1);
        2, 3:    m[i] = CODE_W'(2);
        4:       m[i] = CODE_W'(3);
        default: m[i] = CODE_W'(4);
      endcase
    end
    return m;
  endfunction

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q,   cnt_d;
  logic          tick_q,  tick_d;
  logic [PW-1:0] ptr_q,   ptr_d;
  msg_t          msg_q,   msg_d;
  logic          step_q;

  logic          step_rise;
  logic          advance;
  logic [CW-1:0] period_m1;

  assign step_rise = step & ~step_q;

  // Terminal count for the selected speed. Compared with >= so that a speed
  // raised mid-period wraps on the very next cycle instead of running the
  // counter all the way around.
  assign period_m1 = CW'((TICK_DIV >> speed) - 1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tick_d  = 1'b0;
    ptr_d   = ptr_q;
    msg_d   = msg_q;
    advance = 1'b0;

    case (state_q)
      S_STOP: begin
        cnt_d = '0;
        if (run)            state_d = S_RUN;
        else if (step_rise) state_d = S_STEP;
      end
      S_RUN: begin
        if (!run) begin
          // Partial period is thrown away; resuming starts a full one.
          state_d = S_STOP;
          cnt_d   = '0;
        end else if (cnt_q >= period_m1) begin
          cnt_d   = '0;
          tick_d  = 1'b1;
          advance = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_STEP: begin
        // Single-cycle state: one advance, then back to STOP. Step is not
        // looked at here, so a held step cannot retrigger.
        cnt_d   = '0;
        advance = 1'b1;
        state_d = S_STOP;
      end
      default: begin
        cnt_d   = '0;
        state_d = S_STOP;
      end
    endcase

    // PW-bit arithmetic gives the modulo-MSG_LEN wrap in both directions.
    if (advance)
      ptr_d = dir ? (ptr_q - PW'(1)) : (ptr_q + PW'(1));

    // Write is independent of the FSM; the window after an advance reads
    // the buffer including this write since both land on the same edge.
    if (wr.wr_en)
      msg_d[wr.wr_addr] = wr.wr_data;
  end

  always_ff @(posedge CLOCK_50 or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= S_STOP;
      cnt_q   <= '0;
      tick_q  <= 1'b0;
      ptr_q   <= '0;
      msg_q   <= init_msg();
      step_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tick_q  <= tick_d;
      ptr_q   <= ptr_d;
      msg_q   <= msg_d;
      step_q  <= step;
    end
  end

  // Window: digit K (3 = leftmost) shows slot ptr + 3 - K.
  logic [3:0][CODE_W-1:0] win;
  for (genvar k = 0; k < 4; k++) begin : g_win
    logic [PW-1:0] idx;
    assign idx    = ptr_q + PW'(3 - k);
    assign win[k] = msg_q[idx];
  end

  assign code3 = win[3];
  assign code2 = win[2];
  assign code1 = win[1];
  assign code0 = win[0];
  assign ptr   = ptr_q;
  assign tick  = tick_q;
  assign state = state_q;

endmodule

// File: tb/tb_hex_scroll_ctrl.sv
module tb_hex_scroll_ctrl;
  localparam int TD = 8;
  localparam int ML = 8;
  localparam int CW = 3;
  localparam int PW = 3;

  logic          CLOCK_50 = 1'b0;
  logic          Resetn   = 1'b0;
  logic          run = 1'b0, dir = 1'b0, step = 1'b0;
  logic [1:0]    speed = 2'd0;
  logic [CW-1:0] code3, code2, code1, code0;
  logic [PW-1:0] ptr;
  logic          tick;
  logic [1:0]    state;

  hex_scroll_ctrl_if #(.PW(PW), .CODE_W(CW)) wbus ();

  always #5 CLOCK_50 = ~CLOCK_50;

  hex_scroll_ctrl #(.TICK_DIV(TD), .MSG_LEN(ML), .CODE_W(CW)) dut (
    .CLOCK_50 (CLOCK_50),
    .Resetn   (Resetn),
    .run      (run),
    .dir      (dir),
    .step     (step),
    .speed    (speed),
    .wr       (wbus),
    .code3    (code3),
    .code2    (code2),
    .code1    (code1),
    .code0    (code0),
    .ptr      (ptr),
    .tick     (tick),
    .state    (state)
  );

  int n_pass = 0;
  int n_tot  = 0;

  // ---- behavioural reference: mode, cycles since last advance, buffer ----
  int m_msg [ML];
  int m_ptr;
  int m_mode;     // 0 stopped, 1 running, 2 single step
  int m_elapsed;  // running cycles since entering RUN or last tick
  int m_tick;
  int m_prev_step;

  function automatic void model_reset();
    int hello [5] = '{0, 1, 2, 2, 3};
    for (int i = 0; i < ML; i++) m_msg[i] = (i < 5) ? hello[i] : 4;
    m_ptr = 0; m_mode = 0; m_elapsed = 0; m_tick = 0; m_prev_step = 0;
  endfunction

  // Effect of one rising clock edge on the model, using current inputs.
  function automatic void model_edge();
    int period = TD >> speed;
    bit moves  = 0;
    int nmode  = m_mode;
    m_tick = 0;
    if (m_mode == 0) begin
      m_elapsed = 0;
      if (run) nmode = 1;
      else if (step && !m_prev_step) nmode = 2;
    end else if (m_mode == 1) begin
      if (!run) begin nmode = 0; m_elapsed = 0; end
      else if (m_elapsed + 1 >= period) begin m_elapsed = 0; m_tick = 1; moves = 1; end
      else m_elapsed++;
    end else begin
      moves = 1; nmode = 0; m_elapsed = 0;
    end
    if (wbus.wr_en) m_msg[wbus.wr_addr] = wbus.wr_data;
    if (moves) m_ptr = (m_ptr + (dir ? ML - 1 : 1)) % ML;
    m_mode = nmode;
    m_prev_step = step;
  endfunction

  function automatic logic [17:0] exp_vec();
    logic [17:0] v;
    v[17:16] = 2'(m_mode);
    v[15:13] = 3'(m_ptr);
    v[12]    = 1'(m_tick);
    for (int k = 0; k < 4; k++) v[3*k +: 3] = 3'(m_msg[(m_ptr + 3 - k) % ML]);
    return v;
  endfunction

  function automatic logic [17:0] act_vec();
    return {state, ptr, tick, code3, code2, code1, code0};
  endfunction

  task automatic cyc();
    model_edge();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic do_reset();
    run = 0; dir = 0; step = 0; speed = 0; wbus.wr_en = 0;
    Resetn = 0; model_reset();
    #2 Resetn = 1;
  endtask

  // ---------------------------------------------------------------------
  task automatic test_reset();
    run = 0; dir = 0; step = 0; speed = 0;
    wbus.wr_en = 0; wbus.wr_addr = 0; wbus.wr_data = 0;
    Resetn = 0; model_reset();
    #12 Resetn = 1;
    #1;
    n_tot++;
    if (act_vec() !== {2'd0, 3'd0, 1'b0, 3'd0, 3'd1, 3'd2, 3'd2})
      $display("FAIL reset_state got %h want %h", act_vec(), {2'd0, 3'd0, 1'b0, 3'd0, 3'd1, 3'd2, 3'd2});
    else n_pass++;
    run = 1; speed = 3;
    for (int i = 0; i < 4; i++) cyc();
    n_tot++;
    if (ptr !== 3'd3 || tick !== 1'b1) $display("FAIL pre_async_reset got ptr=%0d tick=%0b want ptr=3 tick=1", ptr, tick);
    else n_pass++;
    #3 Resetn = 0; model_reset();
    #1;
    n_tot++;
    if (act_vec() !== {2'd0, 3'd0, 1'b0, 3'd0, 3'd1, 3'd2, 3'd2})
      $display("FAIL async_reset got %h want %h", act_vec(), {2'd0, 3'd0, 1'b0, 3'd0, 3'd1, 3'd2, 3'd2});
    else n_pass++;
    Resetn = 1; run = 0; speed = 0;
    cyc();
  endtask

  task automatic test_scroll_left();
    int first = -1;
    do_reset();
    run = 1;
    for (int i = 1; i <= 66; i++) begin
      cyc();
      if (tick === 1'b1 && first < 0) first = i;
      n_tot++;
      if (act_vec() !== exp_vec()) $display("FAIL scroll_left cyc %0d got %h want %h", i, act_vec(), exp_vec());
      else n_pass++;
      if (i == 25) begin
        n_tot++;
        if ({ptr, code3, code2, code1, code0} !== {3'd3, 3'd2, 3'd3, 3'd4, 3'd4})
          $display("FAIL window_ptr3 got %h want %h", {ptr, code3, code2, code1, code0}, {3'd3, 3'd2, 3'd3, 3'd4, 3'd4});
        else n_pass++;
      end
      if (i == 49) begin
        n_tot++;
        if ({ptr, code3, code2, code1, code0} !== {3'd6, 3'd4, 3'd4, 3'd0, 3'd1})
          $display("FAIL window_ptr6 got %h want %h", {ptr, code3, code2, code1, code0}, {3'd6, 3'd4, 3'd4, 3'd0, 3'd1});
        else n_pass++;
      end
      if (i == 65) begin
        n_tot++;
        if (ptr !== 3'd0 || tick !== 1'b1) $display("FAIL wrap_to_0 got ptr=%0d tick=%0b want ptr=0 tick=1", ptr, tick);
        else n_pass++;
      end
    end
    n_tot++;
    if (first != 9) $display("FAIL first_tick edge got %0d want 9", first);
    else n_pass++;
  endtask

  task automatic test_dir_speed();
    do_reset();
    run = 1; dir = 1;
    for (int i = 0; i < 9; i++) cyc();
    n_tot++;
    if ({tick, ptr, code3, code2, code1, code0} !== {1'b1, 3'd7, 3'd4, 3'd0, 3'd1, 3'd2})
      $display("FAIL dir_right_wrap got %h want %h", {tick, ptr, code3, code2, code1, code0}, {1'b1, 3'd7, 3'd4, 3'd0, 3'd1, 3'd2});
    else n_pass++;
    speed = 3;
    for (int i = 1; i <= 4; i++) begin
      cyc();
      n_tot++;
      if (tick !== 1'b1 || ptr !== 3'(7 - i)) $display("FAIL speed3 cyc %0d got tick=%0b ptr=%0d want tick=1 ptr=%0d", i, tick, ptr, 7 - i);
      else n_pass++;
    end
    speed = 0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      n_tot++;
      if (tick !== 1'b0) $display("FAIL speed0_hold cyc %0d got tick=%0b want 0", i, tick);
      else n_pass++;
    end
    speed = 2;
    cyc();
    n_tot++;
    if (tick !== 1'b1 || ptr !== 3'd2) $display("FAIL speed_raise got tick=%0b ptr=%0d want tick=1 ptr=2", tick, ptr);
    else n_pass++;
    run = 0; dir = 0; speed = 0;
    cyc();
  endtask

  task automatic test_step();
    do_reset();
    step = 1;
    cyc();
    n_tot++;
    if (state !== 2'd2 || ptr !== 3'd0) $display("FAIL step_enter got state=%0d ptr=%0d want state=2 ptr=0", state, ptr);
    else n_pass++;
    cyc();
    n_tot++;
    if (state !== 2'd0 || ptr !== 3'd1 || tick !== 1'b0) $display("FAIL step_exit got state=%0d ptr=%0d tick=%0b want 0 1 0", state, ptr, tick);
    else n_pass++;
    for (int i = 0; i < 3; i++) cyc();
    n_tot++;
    if (state !== 2'd0 || ptr !== 3'd1 || tick !== 1'b0) $display("FAIL step_held got state=%0d ptr=%0d tick=%0b want 0 1 0", state, ptr, tick);
    else n_pass++;
    step = 0; cyc();
    run = 1; cyc();
    step = 1; cyc();
    step = 0;
    for (int i = 0; i < 3; i++) cyc();
    n_tot++;
    if (state !== 2'd1 || ptr !== 3'd1) $display("FAIL step_in_run got state=%0d ptr=%0d want state=1 ptr=1", state, ptr);
    else n_pass++;
    run = 0; cyc();
  endtask

  task automatic test_resume();
    int first = -1;
    do_reset();
    run = 1;
    for (int i = 0; i < 5; i++) cyc();
    run = 0;
    for (int i = 0; i < 3; i++) cyc();
    run = 1;
    for (int i = 1; i <= 40 && first < 0; i++) begin
      cyc();
      if (tick === 1'b1) first = i;
    end
    n_tot++;
    if (first != 9) $display("FAIL resume_first_tick got %0d want 9 (-1 = none within bound)", first);
    else n_pass++;
    run = 0; cyc();
  endtask

  task automatic test_write();
    do_reset();
    wbus.wr_en = 1; wbus.wr_addr = 3'd1; wbus.wr_data = 3'd3;
    cyc();
    wbus.wr_en = 0;
    n_tot++;
    if (code2 !== 3'd3 || code3 !== 3'd0) $display("FAIL write_window got code3=%0d code2=%0d want 0 3", code3, code2);
    else n_pass++;
    do_reset();
    run = 1;
    for (int i = 0; i < 8; i++) cyc();
    wbus.wr_en = 1; wbus.wr_addr = 3'd1; wbus.wr_data = 3'd3;
    cyc();
    wbus.wr_en = 0;
    n_tot++;
    if ({tick, ptr, code3} !== {1'b1, 3'd1, 3'd3}) $display("FAIL write_with_tick got %h want %h", {tick, ptr, code3}, {1'b1, 3'd1, 3'd3});
    else n_pass++;
    run = 0; cyc();
  endtask

  task automatic test_random();
    int errs = 0;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(19) == 0) run = ~run;
      if ($urandom_range(29) == 0) dir = ~dir;
      if ($urandom_range(39) == 0) speed = 2'($urandom_range(3));
      step = ($urandom_range(3) == 0);
      wbus.wr_en   = ($urandom_range(3) == 0);
      wbus.wr_addr = 3'($urandom_range(7));
      wbus.wr_data = 3'($urandom_range(7));
      cyc();
      n_tot++;
      if (act_vec() !== exp_vec()) begin
        errs++;
        if (errs <= 10) $display("FAIL random cyc %0d got %h want %h", i, act_vec(), exp_vec());
      end else n_pass++;
    end
    wbus.wr_en = 0; run = 0; step = 0;
  endtask

  initial begin
    test_reset();
    test_scroll_left();
    test_dir_speed();
    test_step();
    test_resume();
    test_write();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
